// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state encoding, size codes and load-extension helper for mem_ctrl.
package mem_ctrl_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned RAM_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      MEM_IDLE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2
   } mem_state_e;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_B:  return 3'd1;
         SIZE_H:  return 3'd2;
         SIZE_W:  return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] raw,
                                                         input logic [2:0]            nbytes,
                                                         input logic                  sgn);
      logic [DATA_WIDTH-1:0] res;
      case (nbytes)
         3'd1:    res = {{24{sgn & raw[7]}}, raw[7:0]};
         3'd2:    res = {{16{sgn & raw[15]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: fetch and load/store slots, load/store priority,
// per-byte RAM cycles, assembled and extended read data with a one-cycle ready pulse.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_rollback,
   input  logic                      in_fetch_ena,
   input  logic [DATA_WIDTH-1:0]     in_fetch_addr,
   output logic                      out_fetch_ready,
   output logic [DATA_WIDTH-1:0]     out_fetch_inst,
   input  logic                      in_ls_ena,
   input  logic                      in_ls_write,
   input  logic [1:0]                in_ls_size,
   input  logic                      in_ls_signed,
   input  logic [DATA_WIDTH-1:0]     in_ls_addr,
   input  logic [DATA_WIDTH-1:0]     in_ls_data,
   output logic                      out_ls_ready,
   output logic [DATA_WIDTH-1:0]     out_ls_data,
   output logic                      out_ram_rw,
   output logic [DATA_WIDTH-1:0]     out_ram_addr,
   output logic [RAM_DATA_WIDTH-1:0] out_ram_dout,
   input  logic [RAM_DATA_WIDTH-1:0] in_ram_din
);

   mem_state_e            state_q;
   logic                  fetch_pend_q;
   logic [DATA_WIDTH-1:0] fetch_addr_q;
   logic                  ls_pend_q, ls_write_q, ls_signed_q;
   logic [1:0]            ls_size_q;
   logic [DATA_WIDTH-1:0] ls_addr_q, ls_data_q;
   logic                  act_ls_q, act_signed_q;
   logic [2:0]            act_n_q, cyc_q;
   logic [DATA_WIDTH-1:0] act_addr_q, act_data_q, rd_data_q;

   logic                  ls_slot_ok, ls_take, ls_req, fetch_req;
   logic                  src_write, src_signed;
   logic [1:0]            src_size;
   logic [DATA_WIDTH-1:0] src_addr, src_data, src_fetch_addr;
   logic [2:0]            edge_n;
   logic [1:0]            rd_lane;
   logic [DATA_WIDTH-1:0] rd_next;

   function automatic logic [DATA_WIDTH-1:0] insert_byte(input logic [DATA_WIDTH-1:0]     word,
                                                         input logic [1:0]                lane,
                                                         input logic [RAM_DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] res;
      res = word;
      res[{lane, 3'b000} +: 8] = b;
      return res;
   endfunction

   always_comb begin
      // Rollback voids a pending or incoming load/fetch; stores survive it.
      ls_slot_ok     = ls_pend_q & (ls_write_q | ~in_rollback);
      ls_take        = in_ls_ena & (in_ls_write | ~in_rollback);
      ls_req         = ls_slot_ok | ls_take;
      fetch_req      = ~in_rollback & (fetch_pend_q | in_fetch_ena);
      src_write      = ls_slot_ok ? ls_write_q  : in_ls_write;
      src_signed     = ls_slot_ok ? ls_signed_q : in_ls_signed;
      src_size       = ls_slot_ok ? ls_size_q   : in_ls_size;
      src_addr       = ls_slot_ok ? ls_addr_q   : in_ls_addr;
      src_data       = ls_slot_ok ? ls_data_q   : in_ls_data;
      src_fetch_addr = fetch_pend_q ? fetch_addr_q : in_fetch_addr;
      edge_n         = cyc_q + 3'd1;
      rd_lane        = cyc_q[1:0] - 2'd1;
      rd_next        = insert_byte(rd_data_q, rd_lane, in_ram_din);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= MEM_IDLE;
         fetch_pend_q    <= 1'b0;
         fetch_addr_q    <= '0;
         ls_pend_q       <= 1'b0;
         ls_write_q      <= 1'b0;
         ls_signed_q     <= 1'b0;
         ls_size_q       <= '0;
         ls_addr_q       <= '0;
         ls_data_q       <= '0;
         act_ls_q        <= 1'b0;
         act_signed_q    <= 1'b0;
         act_n_q         <= '0;
         act_addr_q      <= '0;
         act_data_q      <= '0;
         cyc_q           <= '0;
         rd_data_q       <= '0;
         out_fetch_ready <= 1'b0;
         out_fetch_inst  <= '0;
         out_ls_ready    <= 1'b0;
         out_ls_data     <= '0;
         out_ram_rw      <= 1'b0;
         out_ram_addr    <= '0;
         out_ram_dout    <= '0;
      end else begin
         out_fetch_ready <= 1'b0;
         out_ls_ready    <= 1'b0;

         if (in_rollback) begin
            fetch_pend_q <= 1'b0;
         end else if (in_fetch_ena) begin
            fetch_pend_q <= 1'b1;
            fetch_addr_q <= in_fetch_addr;
         end

         if (ls_take) begin
            ls_pend_q   <= 1'b1;
            ls_write_q  <= in_ls_write;
            ls_signed_q <= in_ls_signed;
            ls_size_q   <= in_ls_size;
            ls_addr_q   <= in_ls_addr;
            ls_data_q   <= in_ls_data;
         end else if (in_rollback && !ls_write_q) begin
            ls_pend_q <= 1'b0;
         end

         case (state_q)
            MEM_IDLE: begin
               if (ls_req) begin
                  ls_pend_q    <= 1'b0;
                  act_ls_q     <= 1'b1;
                  act_signed_q <= src_signed;
                  act_n_q      <= size_bytes(src_size);
                  act_addr_q   <= src_addr;
                  act_data_q   <= src_data;
                  cyc_q        <= '0;
                  rd_data_q    <= '0;
                  out_ram_addr <= src_addr;
                  if (src_write) begin
                     state_q      <= MEM_WRITE;
                     out_ram_rw   <= 1'b1;
                     out_ram_dout <= src_data[7:0];
                  end else begin
                     state_q <= MEM_READ;
                  end
               end else if (fetch_req) begin
                  fetch_pend_q <= 1'b0;
                  act_ls_q     <= 1'b0;
                  act_signed_q <= 1'b0;
                  act_n_q      <= 3'd4;
                  act_addr_q   <= src_fetch_addr;
                  act_data_q   <= '0;
                  cyc_q        <= '0;
                  rd_data_q    <= '0;
                  out_ram_addr <= src_fetch_addr;
                  state_q      <= MEM_READ;
               end
            end
            MEM_READ: begin
               if (in_rollback) begin
                  state_q <= MEM_IDLE;
               end else begin
                  // Addresses lead captured bytes by two edges.
                  cyc_q <= edge_n;
                  if (edge_n < act_n_q) out_ram_addr <= act_addr_q + {29'd0, edge_n};
                  if (edge_n >= 3'd2) rd_data_q <= rd_next;
                  if (edge_n == act_n_q + 3'd1) begin
                     state_q <= MEM_IDLE;
                     if (act_ls_q) begin
                        out_ls_ready <= 1'b1;
                        out_ls_data  <= extend_load(rd_next, act_n_q, act_signed_q);
                     end else begin
                        out_fetch_ready <= 1'b1;
                        out_fetch_inst  <= rd_next;
                     end
                  end
               end
            end
            MEM_WRITE: begin
               cyc_q <= edge_n;
               if (edge_n < act_n_q) begin
                  out_ram_addr <= act_addr_q + {29'd0, edge_n};
                  out_ram_dout <= act_data_q[{edge_n[1:0], 3'b000} +: 8];
               end else begin
                  out_ram_rw   <= 1'b0;
                  out_ls_ready <= 1'b1;
                  state_q      <= MEM_IDLE;
               end
            end
            default: state_q <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table vectors, corner sequences and a
// randomized run checked against an array-based memory model.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_rollback = 1'b0;
   logic        in_fetch_ena = 1'b0;
   logic [31:0] in_fetch_addr = '0;
   logic        out_fetch_ready;
   logic [31:0] out_fetch_inst;
   logic        in_ls_ena = 1'b0;
   logic        in_ls_write = 1'b0;
   logic [1:0]  in_ls_size = '0;
   logic        in_ls_signed = 1'b0;
   logic [31:0] in_ls_addr = '0;
   logic [31:0] in_ls_data = '0;
   logic        out_ls_ready;
   logic [31:0] out_ls_data;
   logic        out_ram_rw;
   logic [31:0] out_ram_addr;
   logic [7:0]  out_ram_dout;
   logic [7:0]  in_ram_din;

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .in_rollback     (in_rollback),
      .in_fetch_ena    (in_fetch_ena),
      .in_fetch_addr   (in_fetch_addr),
      .out_fetch_ready (out_fetch_ready),
      .out_fetch_inst  (out_fetch_inst),
      .in_ls_ena       (in_ls_ena),
      .in_ls_write     (in_ls_write),
      .in_ls_size      (in_ls_size),
      .in_ls_signed    (in_ls_signed),
      .in_ls_addr      (in_ls_addr),
      .in_ls_data      (in_ls_data),
      .out_ls_ready    (out_ls_ready),
      .out_ls_data     (out_ls_data),
      .out_ram_rw      (out_ram_rw),
      .out_ram_addr    (out_ram_addr),
      .out_ram_dout    (out_ram_dout),
      .in_ram_din      (in_ram_din)
   );

   // Synchronous byte RAM, 1 KiB aliased over the address space.
   logic [7:0] ram [1024];
   logic       pre_we = 1'b0;
   logic [9:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   always @(posedge clk) begin
      if (rst) for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      else if (pre_we) ram[pre_addr] <= pre_data;
      else if (out_ram_rw) ram[out_ram_addr[9:0]] <= out_ram_dout;
      in_ram_din <= ram[out_ram_addr[9:0]];
   end

   int         total = 0;
   int         bad = 0;
   logic [7:0] ref_mem [1024];

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input logic sg);
      longint v = 0;
      for (int k = 0; k < n; k++) begin
         logic [31:0] ak;
         ak = a + 32'(k);
         v += longint'(ref_mem[ak[9:0]]) << (8 * k);
      end
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   task automatic model_write(input logic [31:0] a, input int n, input logic [31:0] d);
      for (int k = 0; k < n; k++) begin
         logic [31:0] ak;
         ak = a + 32'(k);
         ref_mem[ak[9:0]] = 8'(d >> (8 * k));
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      @(negedge clk);
      pre_we   = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic run_ls(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] got, output int lat, output int rwc);
      in_ls_write  = w;
      in_ls_size   = sz;
      in_ls_signed = sg;
      in_ls_addr   = a;
      in_ls_data   = d;
      in_ls_ena    = 1'b1;
      got = '0;
      lat = -1;
      rwc = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         in_ls_ena = 1'b0;
         if (out_ram_rw) rwc++;
         if (out_ls_ready) begin
            got = out_ls_data;
            lat = c;
            break;
         end
      end
      @(negedge clk);
      check("ls_ready_width", 32'(out_ls_ready), 32'h0);
   endtask

   task automatic run_fetch(input logic [31:0] a, output logic [31:0] got, output int lat);
      in_fetch_addr = a;
      in_fetch_ena  = 1'b1;
      got = '0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         in_fetch_ena = 1'b0;
         if (out_fetch_ready) begin
            got = out_fetch_inst;
            lat = c;
            break;
         end
      end
      @(negedge clk);
      check("fetch_ready_width", 32'(out_fetch_ready), 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got, exp, ls_got, f_got;
      int          lat, rwc, ls_lat, f_lat, cnt, n;
      logic        w, sg;
      logic [1:0]  sz;
      logic [31:0] a, d;

      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ram_rw", 32'(out_ram_rw), 32'h0);
      check("rst_ram_addr", out_ram_addr, 32'h0);
      check("rst_ram_dout", 32'(out_ram_dout), 32'h0);
      check("rst_fetch_ready", 32'(out_fetch_ready), 32'h0);
      check("rst_ls_ready", 32'(out_ls_ready), 32'h0);
      check("rst_fetch_inst", out_fetch_inst, 32'h0);
      check("rst_ls_data", out_ls_data, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      preload(10'h010, 8'h13);
      preload(10'h011, 8'h05);
      preload(10'h012, 8'h00);
      preload(10'h013, 8'h00);

      // Basic fetch
      run_fetch(32'h10, got, lat);
      check("fetch_data", got, 32'h00000513);
      check("fetch_latency", 32'(lat), 32'd6);

      // Table vectors
      vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h00000020, 32'h00000080, 32'h0,        2};
      vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h00000020, 32'h0,        32'hFFFFFF80, 3};
      vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h00000020, 32'h0,        32'h00000080, 3};
      vecs[3]  = '{1'b1, 2'd2, 1'b0, 32'h00000100, 32'hDEADBEEF, 32'h0,        5};
      vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        32'hDEADBEEF, 6};
      vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h00000102, 32'h0,        32'hFFFFDEAD, 4};
      vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h00000102, 32'h0,        32'h0000DEAD, 4};
      vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h00000100, 32'h0,        32'hFFFFBEEF, 4};
      vecs[8]  = '{1'b1, 2'd1, 1'b0, 32'h00000200, 32'hAAAA1234, 32'h0,        3};
      vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h00000200, 32'h0,        32'h00001234, 6};
      vecs[10] = '{1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h11223344, 32'h0,        5};
      vecs[11] = '{1'b0, 2'd2, 1'b1, 32'hFFFFFFFE, 32'h0,        32'h11223344, 6};
      vecs[12] = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        32'hFFFFFFDE, 3};
      vecs[13] = '{1'b0, 2'd1, 1'b1, 32'h00000200, 32'h0,        32'h00001234, 4};

      for (int i = 0; i < 14; i++) begin
         run_ls(vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].d, got, lat, rwc);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         if (vecs[i].w) begin
            check($sformatf("vec%0d_rw_cycles", i), 32'(rwc), 32'(nbytes(vecs[i].sz)));
            model_write(vecs[i].a, nbytes(vecs[i].sz), vecs[i].d);
         end else begin
            check($sformatf("vec%0d_data", i), got, vecs[i].exp);
         end
      end
      check("ram_word_bytes", {ram[10'h103], ram[10'h102], ram[10'h101], ram[10'h100]},
            32'hDEADBEEF);

      // Fetch and load on the same idle edge: load first, fetch right after
      in_fetch_addr = 32'h10;
      in_fetch_ena  = 1'b1;
      in_ls_write   = 1'b0;
      in_ls_size    = 2'd0;
      in_ls_signed  = 1'b0;
      in_ls_addr    = 32'h20;
      in_ls_ena     = 1'b1;
      ls_lat = -1;
      f_lat  = -1;
      ls_got = '0;
      f_got  = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         in_fetch_ena = 1'b0;
         in_ls_ena    = 1'b0;
         if (out_ls_ready && ls_lat < 0) begin ls_lat = c; ls_got = out_ls_data; end
         if (out_fetch_ready && f_lat < 0) begin f_lat = c; f_got = out_fetch_inst; end
      end
      check("arb_ls_latency", 32'(ls_lat), 32'd3);
      check("arb_ls_data", ls_got, 32'h00000080);
      check("arb_fetch_latency", 32'(f_lat), 32'd9);
      check("arb_fetch_data", f_got, 32'h00000513);

      // Rollback in the third cycle of a fetch, then refetch from idle
      in_fetch_addr = 32'h10;
      in_fetch_ena  = 1'b1;
      @(negedge clk);
      in_fetch_ena = 1'b0;
      @(negedge clk);
      @(negedge clk);
      in_rollback = 1'b1;
      @(negedge clk);
      in_rollback = 1'b0;
      check("rb_ram_rw", 32'(out_ram_rw), 32'h0);
      in_fetch_ena = 1'b1;
      cnt = 0;
      f_lat = -1;
      f_got = '0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         in_fetch_ena = 1'b0;
         if (out_fetch_ready) begin
            cnt++;
            if (f_lat < 0) begin f_lat = c; f_got = out_fetch_inst; end
         end
      end
      check("rb_fetch_pulses", 32'(cnt), 32'd1);
      check("rb_refetch_latency", 32'(f_lat), 32'd6);
      check("rb_refetch_data", f_got, 32'h00000513);

      // Rollback during a half store with a load pending behind it
      in_ls_write  = 1'b1;
      in_ls_size   = 2'd1;
      in_ls_signed = 1'b0;
      in_ls_addr   = 32'h300;
      in_ls_data   = 32'h0000BBAA;
      in_ls_ena    = 1'b1;
      @(negedge clk);
      in_ls_write = 1'b0;
      in_ls_size  = 2'd2;
      in_ls_data  = 32'h0;
      @(negedge clk);
      in_ls_ena   = 1'b0;
      in_rollback = 1'b1;
      @(negedge clk);
      in_rollback = 1'b0;
      check("rb_store_ready", 32'(out_ls_ready), 32'h1);
      cnt = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         if (out_ls_ready) cnt++;
      end
      check("rb_load_dropped", 32'(cnt), 32'd0);
      check("rb_store_bytes", {16'h0, ram[10'h301], ram[10'h300]}, 32'h0000BBAA);
      model_write(32'h300, 2, 32'h0000BBAA);

      // Asynchronous reset in the middle of a fetch
      in_fetch_addr = 32'h10;
      in_fetch_ena  = 1'b1;
      @(negedge clk);
      in_fetch_ena = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_ram_rw", 32'(out_ram_rw), 32'h0);
      check("mid_rst_ram_addr", out_ram_addr, 32'h0);
      check("mid_rst_fetch_inst", out_fetch_inst, 32'h0);
      check("mid_rst_ls_data", out_ls_data, 32'h0);
      #1 rst = 1'b0;
      cnt = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (out_fetch_ready || out_ls_ready) cnt++;
      end
      check("mid_rst_no_ready", 32'(cnt), 32'd0);
      run_fetch(32'h10, got, lat);
      check("mid_rst_refetch", got, 32'h00000513);

      // Randomized traffic against the array model
      for (int i = 0; i < 80; i++) begin
         a  = $urandom();
         d  = $urandom();
         sz = 2'($urandom_range(0, 2));
         sg = 1'($urandom_range(0, 1));
         n  = nbytes(sz);
         case ($urandom_range(0, 2))
            0: begin
               w = 1'b1;
               run_ls(w, sz, sg, a, d, got, lat, rwc);
               check("rnd_store_latency", 32'(lat), 32'(n + 1));
               check("rnd_store_rw_cycles", 32'(rwc), 32'(n));
               model_write(a, n, d);
            end
            1: begin
               w = 1'b0;
               exp = model_read(a, n, sg);
               run_ls(w, sz, sg, a, d, got, lat, rwc);
               check("rnd_load_latency", 32'(lat), 32'(n + 2));
               check("rnd_load_data", got, exp);
            end
            default: begin
               exp = model_read(a, 4, 1'b0);
               run_fetch(a, got, lat);
               check("rnd_fetch_latency", 32'(lat), 32'd6);
               check("rnd_fetch_data", got, exp);
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Single-port memory controller between the instruction fetcher's i-cache miss path, the load/store queue and the byte-wide synchronous RAM. It latches one-cycle request pulses from both clients, arbitrates with load/store priority, and serializes each 1/2/4-byte access into per-byte RAM cycles. It returns assembled, extended read data with a one-cycle ready pulse and discards speculative reads on rollback.

## Interface
- No parameters. Widths come from `constant.v`: `DATA_WIDTH` is 32 bits; the RAM port is 8 bits.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `in_rollback` in 1: flush speculative memory work.
- `in_fetch_ena` in 1: one-cycle fetch request pulse.
- `in_fetch_addr` in 32: fetch byte address.
- `out_fetch_ready` out 1: one-cycle done pulse for fetch.
- `out_fetch_inst` out 32: fetched word, valid while ready is high.
- `in_ls_ena` in 1: one-cycle load/store request pulse.
- `in_ls_write` in 1: 1 = store, 0 = load.
- `in_ls_size` in 2: 0 = byte, 1 = half, 2 = word.
- `in_ls_signed` in 1: sign-extend load result.
- `in_ls_addr` in 32: byte address.
- `in_ls_data` in 32: store data; low bytes are used.
- `out_ls_ready` out 1: one-cycle done pulse for load/store.
- `out_ls_data` out 32: load result, valid while ready is high.
- `out_ram_rw` out 1: 1 = write.
- `out_ram_addr` out 32: RAM byte address.
- `out_ram_dout` out 8: write byte.
- `in_ram_din` in 8: read byte, valid one cycle after its address is sampled by RAM.

## Operation
- Pending slots:
  - One fetch slot and one load/store slot. Each captures address and attributes on its `ena` pulse.
  - A second pulse into an occupied slot is a protocol error. Clients never issue one.
- States:
  - `IDLE`: `out_ram_rw`=0, no access in progress.
    - Load/store slot pending → `READ` or `WRITE`.
    - Else fetch slot pending → `READ`.
    - A pulse arriving at an IDLE edge is served directly from that edge; it need not be latched first.
  - `READ`: issue N byte addresses, base..base+N-1, ascending. Capture returned bytes into lanes 0..N-1 (little-endian). After the last byte → `IDLE`.
  - `WRITE`: drive byte k of the store data at base+k with `out_ram_rw`=1, one byte per cycle. After N bytes → `IDLE`.
- Byte count: N = 1, 2 or 4, from `in_ls_size`. Fetch is always N=4.
- Load result:
  - Signed loads sign-extend from bit 8N-1.
  - Unsigned loads zero-fill.
  - Word loads are passed through.
- Rollback, on any edge with `in_rollback`=1:
  - Clear the fetch slot and any pending load.
  - A `READ` in progress aborts: → `IDLE`, no ready pulse, `out_ram_rw`=0.
  - Pending or active stores are unaffected and complete normally.
  - A fetch or load pulse on the same edge as rollback is dropped.
  - A store pulse on that edge is kept.
- No address alignment checks. Addresses wrap modulo 2^32.

## Timing
- Edge 0 is the edge at which a request is accepted.
- Reads:
  - Byte k address is driven from edge k.
  - Byte k is sampled at edge k+2.
  - `*_ready` and data are registered at edge N+1 and high for exactly the following cycle.
  - Word read: ready is high for the cycle after edge 5.
- Writes:
  - Byte k is driven from edge k, with `out_ram_rw`=1 for edges 0..N-1.
  - `out_ls_ready` is registered at edge N.
  - `out_ram_rw` returns to 0 at edge N.
- The controller is `IDLE` during the ready cycle. The next access may start at the following edge.
- Arbitration is evaluated only in `IDLE`. An access in progress is never preempted.
- Reset, asynchronous, including mid-access, sets:
  - state `IDLE`, both slots empty;
  - `out_ram_rw`=0, `out_ram_addr`=0, `out_ram_dout`=0;
  - both ready outputs 0, `out_fetch_inst`=0, `out_ls_data`=0.

## Structure
- `constant.v` holds:
  - state encodings `MEM_IDLE`, `MEM_READ`, `MEM_WRITE`;
  - size codes `SIZE_B`, `SIZE_H`, `SIZE_W`;
  - the `RAM_DATA_WIDTH` macro.
- Single module, no sub-module. Byte-lane assembly and extension are a local function.

## Test plan
- Fetch of 0x00000010 from RAM holding bytes 13,05,00,00 → `out_fetch_ready` one cycle after edge 5, `out_fetch_inst`=0x00000513.
- Signed byte load of 0x80 → `out_ls_data`=0xFFFFFF80. Unsigned byte load of 0x80 → 0x00000080. Both ready after edge 2.
- Word store 0xDEADBEEF to 0x100 → RAM 0x100..0x103 = EF,BE,AD,DE. `out_ram_rw` high for 4 cycles, ready after edge 4.
- Fetch and load pulses on the same IDLE edge → load served first. Fetch starts at the edge after the load's ready cycle and completes normally.
- Rollback during the third cycle of a fetch read → no `out_fetch_ready`, state `IDLE` next cycle. A subsequent fetch to the same address returns the correct word.
- Rollback while a half store is in progress, with a load also pending → store completes and pulses ready. Load is dropped and never pulses ready.
